// File: rtl/skid_pipeline_reg.sv
// ---------------------------------------------------------------------------
// skid_pipeline_reg
//
// Purpose: a two-entry valid/ready pipeline stage, also called a skid buffer.
// Every output is driven straight from a flop, so no combinational path runs
// from any input to any output. The main register drives out_data. The skid
// register catches the one beat that can arrive while downstream is stalled
// and in_ready has not yet dropped.
//
// Optional feature: define SKID_PIPELINE_REG_STALL_CNT_EN to add the
// stall_count output. It is a saturating count of the cycles in which a beat
// was offered downstream but not taken. Flush does not clear it.
//
// Parameters:
//   WIDTH           payload width in bits (>=1)
//   STALL_CNT_WIDTH stall counter width in bits (>=1)
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   flush        in   synchronous discard of all buffered beats
//   in_valid     in   upstream beat valid
//   in_data      in   upstream payload [WIDTH]
//   in_ready     out  upstream may transfer (flop)
//   out_valid    out  downstream beat valid (flop)
//   out_data     out  downstream payload [WIDTH] (flop)
//   out_ready    in   downstream accepts beat
//   stall_count  out  stall counter [STALL_CNT_WIDTH], only with the macro
// ---------------------------------------------------------------------------
module skid_pipeline_reg #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready
`ifdef SKID_PIPELINE_REG_STALL_CNT_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic               inReady_q, inReady_d;
  logic               outValid_q, outValid_d;
  logic               accept;
  logic               pop;

  // Invalid widths produce an empty marker scope, and the elaborated
  // hierarchy shows it.
  if (WIDTH < 1 || STALL_CNT_WIDTH < 1) begin : g_bad_width
  end

  assign accept = in_valid & inReady_q;
  assign pop    = outValid_q & out_ready;

  // The next state and the next data are both worked out here. The handshake
  // flops copy their values from the next state. This keeps them equal to
  // the state decode, but they are still registered.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (accept && pop) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    inReady_d  = (state_d != FULL);
    outValid_d = (state_d != EMPTY);
  end

  // Reset holds in_ready low. It rises at the first edge after reset
  // deasserts, because from then on inReady_d is 1 while the state is EMPTY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      inReady_q  <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      inReady_q  <= inReady_d;
      outValid_q <= outValid_d;
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign out_data  = main_q;

`ifdef SKID_PIPELINE_REG_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] stallCount_q;

  // Counts cycles in which a beat was offered but refused, and saturates at
  // all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCount_q <= '0;
    end else if (outValid_q && !out_ready && !(&stallCount_q)) begin
      stallCount_q <= stallCount_q + STALL_CNT_WIDTH'(1);
    end
  end

  assign stall_count = stallCount_q;
`endif

endmodule

// File: doc/skid_pipeline_reg.md
SKID_PIPELINE_REG -- requirements
Module: skid_pipeline_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter STALL_CNT_WIDTH, default 16, stall counter width in bits (>=1); used only under REQ-027.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all buffered beats.
REQ-006 SHALL have port in_valid  input  1  upstream beat valid.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port in_ready  output  1  upstream may transfer; driven directly from a flop.
REQ-009 SHALL have port out_valid  output  1  downstream beat valid; driven directly from a flop.
REQ-010 SHALL have port out_data  output  WIDTH  downstream payload; driven directly from a flop.
REQ-011 SHALL have port out_ready  input  1  downstream accepts beat.

Function
REQ-012 SHALL define accept = in_valid & in_ready and pop = out_valid & out_ready, both sampled at the rising clk edge.
REQ-013 SHALL hold a main register (drives out_data) and a skid register, and SHALL use a state machine with states EMPTY (neither valid), BUSY (main valid only) and FULL (both valid).
REQ-014 SHALL drive in_ready = 1 in EMPTY and BUSY and 0 in FULL, and out_valid = 1 in BUSY and FULL, so that no combinational path runs between any input and any output.
REQ-015 In EMPTY, on accept, SHALL load main from in_data and go to BUSY; otherwise it SHALL stay in EMPTY.
REQ-016 In BUSY, on accept with pop, SHALL load main from in_data and stay in BUSY.
REQ-017 In BUSY, on accept without pop, SHALL load skid from in_data and go to FULL.
REQ-018 In BUSY, on pop without accept, SHALL go to EMPTY.
REQ-019 In BUSY, with neither accept nor pop, SHALL hold state and data.
REQ-020 In FULL, on pop, SHALL copy skid to main and go to BUSY; otherwise it SHALL hold state and data.
REQ-021 SHALL give a latency of 1 cycle from accept in EMPTY to out_valid, and SHALL sustain one beat per cycle when out_ready is held at 1.
REQ-022 SHALL preserve beat order and SHALL never drop or duplicate a beat.
REQ-023 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 On flush=1, SHALL go to EMPTY at the next edge; flush SHALL override accept and pop that cycle; the beat presented on an accept during flush is discarded; in_ready SHALL be 1 the following cycle.

Reset
REQ-025 While reset=1, SHALL immediately force state EMPTY, in_ready=0, out_valid=0 and out_data=0, and SHALL clear the skid register to 0.
REQ-026 At the first rising clk edge after reset deasserts, SHALL set in_ready=1; a reset asserted mid-transfer SHALL discard all buffered beats with no partial output.

Configuration
REQ-027 When macro SKID_PIPELINE_REG_STALL_CNT_EN is defined, SHALL add output stall_count (STALL_CNT_WIDTH bits, reset 0) that increments by 1 on every cycle with out_valid=1 and out_ready=0, saturates at all-ones, and is not cleared by flush.
REQ-028 When SKID_PIPELINE_REG_STALL_CNT_EN is undefined, SHALL omit the stall_count port and counter logic, with all other behaviour identical.

Verification
REQ-029 Bench SHALL check streaming: reset, then in_valid=1 with data 0x1,0x2,0x3,0x4 and out_ready=1 -> out_data 0x1..0x4 on consecutive cycles starting 1 cycle after first accept; in_ready stays 1.
REQ-030 Bench SHALL check backpressure: out_ready=0, send 0xA then 0xB -> state FULL and in_ready=0 the cycle after 0xB; out_data holds 0xA; after out_ready=1 -> 0xA then 0xB, in_ready=1 one cycle after first pop.
REQ-031 Bench SHALL check flush: in FULL holding 0xA,0xB, assert flush=1 for one cycle with in_valid=1, data 0xC -> next cycle out_valid=0, in_ready=1; 0xC never appears at output.
REQ-032 Bench SHALL check reset mid-operation: in BUSY, assert reset asynchronously between edges -> out_valid=0, out_data=0, in_ready=0 immediately; in_ready=1 after first edge post-deassert.
REQ-033 Bench SHALL check random stress: random in_valid/out_ready over 10000 cycles, WIDTH=8 -> output sequence equals input sequence, no handshake rule violations.
REQ-034 Bench SHALL check the stall counter with SKID_PIPELINE_REG_STALL_CNT_EN defined and STALL_CNT_WIDTH=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_count reads 15 and stays 15.
